// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one bit per clock, with valid/ready handshakes on both the input and the result side.
module bcd_seq_conv #(
    parameter int BIN_WIDTH = 8,
    parameter int BCD_CNT   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_WIDTH-1:0]   bin_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BCD_CNT*4-1:0]   bcd_code,
    output logic                   ovf,
    output logic                   busy
);

    localparam int BCD_W = BCD_CNT * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);
    localparam logic [63:0] LIMIT = 64'd10 ** BCD_CNT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [BCD_W-1:0]     acc_adj;
    logic [BCD_W-1:0]     acc_shift;
    logic [BIN_WIDTH-1:0] bin_shift;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < BCD_CNT; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        // The bit leaving the top nibble is dropped, giving value mod 10**BCD_CNT.
        {acc_shift, bin_shift} = {acc_adj, bin_q} << 1;

        state_d = state_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_code;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (64'(bin_code) >= LIMIT);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = acc_shift;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd_code  = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: a default 8-bit/3-digit instance checked through a result
// scoreboard, plus a 2-digit instance for the overflow/modulo behaviour.
module tb_bcd_seq_conv;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [7:0]  bin_code;
    logic [11:0] bcd_code;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2, busy2;
    logic [7:0]  bin_code2;
    logic [7:0]  bcd_code2;

    logic [12:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    bcd_seq_conv #(.BIN_WIDTH(8), .BCD_CNT(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .bin_code(bin_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_code(bcd_code), .ovf(ovf), .busy(busy)
    );

    bcd_seq_conv #(.BIN_WIDTH(8), .BCD_CNT(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .bin_code(bin_code2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .bcd_code(bcd_code2), .ovf(ovf2), .busy(busy2)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: decimal digit extraction, value mod 10**cnt packed LSD first.
    function automatic logic [39:0] ref_bcd(input int unsigned v, input int cnt);
        logic [39:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < cnt; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [12:0] exp_word(input int unsigned v);
        logic [39:0] r;
        r = ref_bcd(v, 3);
        return {v >= 1000, r[11:0]};
    endfunction

    // Scoreboard: pop one expected result per completed output transfer.
    always @(negedge clk) begin
        logic [12:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({ovf, bcd_code}), 32'(e));
            end
        end
    end

    // Driver: wait for in_ready, present v for one acceptance edge.
    task automatic send(input int unsigned v, input logic hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin_code = 8'(v);
        exp_q.push_back(exp_word(v));
        @(posedge clk);
        #1;
        check("accepted", 32'(busy), 32'd1);
        if (!hold) in_valid = 1'b0;
        bin_code = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run2(input int unsigned v);
        int n;
        logic [39:0] r;
        n = 0;
        @(negedge clk);
        while (!in_ready2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid2 = 1'b1;
        bin_code2 = 8'(v);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        r = ref_bcd(v, 2);
        check("d2_valid", 32'(out_valid2), 32'd1);
        check("d2_bcd", 32'(bcd_code2), 32'(r[7:0]));
        check("d2_ovf", 32'(ovf2), 32'(v >= 100));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; bin_code = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; bin_code2 = '0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd_code), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Latency: result 8 edges after acceptance, in_ready one edge later.
        send(255, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("lat_low", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_high", 32'(out_valid), 32'd1);
        check("bcd_255", 32'(bcd_code), 32'h255);
        @(negedge clk);
        check("ready_back", 32'(in_ready), 32'd1);
        wait_drain();

        send(0, 1'b0);
        send(99, 1'b0);
        send(100, 1'b0);
        wait_drain();

        // Back-pressure: result held while inputs toggle.
        out_ready = 1'b0;
        send(137, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            bin_code = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("hold_bcd", 32'(bcd_code), 32'h137);
            check("hold_ovf", 32'(ovf), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("hold_release_idle", 32'(in_ready), 32'd1);

        // Reset at the 4th SHIFT edge abandons 200; 42 accepted on first edge after.
        send(200, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        bin_code = 8'd42;
        exp_q.push_back(exp_word(42));
        @(posedge clk);
        #1;
        check("accept_after_rst", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_drain();
        check("bcd_42", 32'(bcd_code), 32'h042);

        // Back-to-back with in_valid held high, all 8-bit inputs.
        for (int v = 0; v < 256; v++) begin
            send(v, 1'b1);
        end
        in_valid = 1'b0;
        wait_drain();

        // Two-digit instance: modulo result and overflow flag.
        run2(123);
        run2(99);
        run2(100);
        run2(255);
        run2(7);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
